// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Sequencer for an external load/clear/enable counter. A start request
//   latches the configuration, loads the start value, then pulses the count
//   enable every (prescale+1) cycles until the counter reaches the terminal
//   value. One-shot mode reports done and stops. Auto-reload mode reloads the
//   start value and repeats. A stop request aborts and clears the counter.
//   All strobes are registered so that the counter sees glitch-free controls.

module counter_seq_ctrl #(
    parameter int CNT_W = 16,
    parameter int PS_W  = 8
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [PS_W-1:0]  i_prescale,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_term_val,
    input  logic [CNT_W-1:0] i_cnt_data,
    output logic             o_cnt_en,
    output logic             o_ld,
    output logic             o_clr,
    output logic [CNT_W-1:0] o_ld_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_tick,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // State and latched configuration
    state_t           r_state;
    logic             r_mode;
    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_term;
    logic [PS_W-1:0]  r_pc;

    // Registered strobes towards the counter and the CPU side
    logic             r_cnt_en;
    logic             r_ld;
    logic             r_clr;
    logic             r_done;
    logic             r_tick;

    // Next-state / next-output values
    state_t           w_state_next;
    logic             w_latch;
    logic [PS_W-1:0]  w_pc_next;
    logic             w_cnt_en_next;
    logic             w_ld_next;
    logic             w_clr_next;
    logic             w_done_next;
    logic             w_tick_next;

    // Datapath helpers
    logic [CNT_W-1:0] w_cnt_after;
    logic             w_hit;
    logic             w_terminal;

    // The counter has not yet applied the enable we are driving now, so the
    // value it will hold after this edge is the current value plus that enable.
    // Comparing against this look-ahead value lets the enable drop in the same
    // cycle the terminal value is reached, with no overshoot.
    assign w_cnt_after = i_cnt_data + {{(CNT_W-1){1'b0}}, r_cnt_en};
    assign w_hit       = (r_pc == r_ps);
    assign w_terminal  = (w_cnt_after == r_term);

    // Next-state and next-strobe decode; stop has priority over everything
    always_comb begin
        w_state_next  = r_state;
        w_latch       = 1'b0;
        w_pc_next     = r_pc;
        w_cnt_en_next = 1'b0;
        w_ld_next     = 1'b0;
        w_clr_next    = 1'b0;
        w_done_next   = 1'b0;
        w_tick_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A start together with stop is dropped; stop alone does nothing here
                if (i_start && !i_stop) begin
                    w_latch      = 1'b1;
                    w_state_next = S_LOAD;
                    w_ld_next    = 1'b1;
                end
            end

            S_LOAD: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                    w_clr_next   = 1'b1;
                end else begin
                    w_state_next = S_RUN;
                    w_pc_next    = '0;
                end
            end

            S_RUN: begin
                if (i_stop) begin
                    // Abort wins even over a terminal detected in this cycle
                    w_state_next = S_IDLE;
                    w_clr_next   = 1'b1;
                end else begin
                    w_pc_next = w_hit ? '0 : r_pc + {{(PS_W-1){1'b0}}, 1'b1};
                    if (w_terminal) begin
                        w_tick_next = 1'b1;
                        if (r_mode) begin
                            // Auto-reload: go straight back to loading
                            w_state_next = S_LOAD;
                            w_ld_next    = 1'b1;
                        end else begin
                            w_state_next = S_DONE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_cnt_en_next = w_hit;
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
                w_clr_next   = i_stop;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Configuration captured once per start; inputs may change freely afterwards
    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            r_mode <= 1'b0;
            r_ps   <= '0;
            r_load <= '0;
            r_term <= '0;
        end else if (w_latch) begin
            r_mode <= i_mode;
            r_ps   <= i_prescale;
            r_load <= i_load_val;
            r_term <= i_term_val;
        end
    end

    // Prescale counter, restarted on every load
    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Registered output strobes
    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            r_cnt_en <= 1'b0;
            r_ld     <= 1'b0;
            r_clr    <= 1'b0;
            r_done   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt_en <= w_cnt_en_next;
            r_ld     <= w_ld_next;
            r_clr    <= w_clr_next;
            r_done   <= w_done_next;
            r_tick   <= w_tick_next;
        end
    end

    assign o_cnt_en  = r_cnt_en;
    assign o_ld      = r_ld;
    assign o_clr     = r_clr;
    assign o_ld_data = r_load;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_tick    = r_tick;
    assign o_state   = r_state;

endmodule
